// File: rtl/aip_port_initiator.sv
// AIP bus initiator: runs one write burst, read burst or start-and-wait
// command at a time against a single AIP slave port.
module aip_port_initiator #(
  parameter int DATA_WORD  = 32,
  parameter int LEN_W      = 8,
  parameter int TMO_W      = 16,
  parameter int TMO_CYCLES = 50000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_a,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [1:0]           i_cmd_op,
  input  logic [4:0]           i_cmd_config,
  input  logic [LEN_W-1:0]     i_cmd_len,
  input  logic [DATA_WORD-1:0] i_wr_data,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  output logic [DATA_WORD-1:0] o_rd_data,
  output logic                 o_rd_valid,
  input  logic                 i_rd_ready,
  output logic                 o_done,
  output logic [1:0]           o_status,
  output logic [4:0]           o_configAIP,
  output logic [DATA_WORD-1:0] o_dataInAIP,
  output logic                 o_readAIP,
  output logic                 o_writeAIP,
  output logic                 o_startAIP,
  input  logic [DATA_WORD-1:0] i_dataOutAIP,
  input  logic                 i_intAIP
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_REQ,
    S_RD_CAP,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_TMO = 2'b01;
  localparam logic [1:0] ST_ILL = 2'b10;

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 wr_ready_q, wr_ready_d;
  logic [DATA_WORD-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 done_q, done_d;
  logic [1:0]           status_q, status_d;
  logic [4:0]           cfg_q, cfg_d;
  logic [DATA_WORD-1:0] din_q, din_d;
  logic                 read_q, read_d;
  logic                 write_q, write_d;
  logic                 start_q, start_d;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    tmo_d       = tmo_q;
    cmd_ready_d = cmd_ready_q;
    wr_ready_d  = wr_ready_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    done_d      = 1'b0;
    status_d    = status_q;
    cfg_d       = cfg_q;
    din_d       = din_q;
    read_d      = 1'b0;
    write_d     = 1'b0;
    start_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          cmd_ready_d = 1'b0;
          cfg_d       = i_cmd_config;
          len_d       = i_cmd_len;
          unique case (i_cmd_op)
            2'b00, 2'b01: begin
              if (i_cmd_len == '0) begin
                state_d  = S_DONE;
                done_d   = 1'b1;
                status_d = ST_OK;
              end else if (i_cmd_op == 2'b00) begin
                state_d    = S_WR;
                wr_ready_d = 1'b1;
              end else begin
                state_d = S_RD_REQ;
                read_d  = 1'b1;
              end
            end
            2'b10: begin
              state_d = S_START;
              start_d = 1'b1;
              tmo_d   = '0;
            end
            default: begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              status_d = ST_ILL;
            end
          endcase
        end
      end
      S_WR: begin
        // wr_ready low here means the final strobe is on the bus now
        if (!wr_ready_q) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          status_d = ST_OK;
        end else if (i_wr_valid) begin
          din_d   = i_wr_data;
          write_d = 1'b1;
          len_d   = len_q - LEN_ONE;
          if (len_q == LEN_ONE) wr_ready_d = 1'b0;
        end
      end
      S_RD_REQ: state_d = S_RD_CAP;
      S_RD_CAP: begin
        if (!rd_valid_q) begin
          rd_data_d  = i_dataOutAIP;
          rd_valid_d = 1'b1;
        end else if (i_rd_ready) begin
          rd_valid_d = 1'b0;
          len_d      = len_q - LEN_ONE;
          if (len_q == LEN_ONE) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            status_d = ST_OK;
          end else begin
            state_d = S_RD_REQ;
            read_d  = 1'b1;
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (i_intAIP) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          status_d = ST_OK;
        end else if (tmo_q == TMO_LAST) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          status_d = ST_TMO;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_a) begin
    if (!i_rst_a) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      tmo_q       <= '0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= '0;
      cfg_q       <= '0;
      din_q       <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      tmo_q       <= tmo_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      status_q    <= status_d;
      cfg_q       <= cfg_d;
      din_q       <= din_d;
      read_q      <= read_d;
      write_q     <= write_d;
      start_q     <= start_d;
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_wr_ready  = wr_ready_q;
  assign o_rd_data   = rd_data_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_done      = done_q;
  assign o_status    = status_q;
  assign o_configAIP = cfg_q;
  assign o_dataInAIP = din_q;
  assign o_readAIP   = read_q;
  assign o_writeAIP  = write_q;
  assign o_startAIP  = start_q;

endmodule

// File: tb/tb_aip_port_initiator.sv
// Bench for aip_port_initiator: directed and random commands against
// a bus-level model of the AIP slave and the command rules.
module tb_aip_port_initiator;
  localparam int DW  = 32;
  localparam int LW  = 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [4:0]    cmd_cfg = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          done;
  logic [1:0]    status;
  logic [4:0]    cfg_aip;
  logic [DW-1:0] din_aip;
  logic          rd_aip;
  logic          wr_aip;
  logic          st_aip;
  logic [DW-1:0] dout_aip = '0;
  logic          int_aip = 1'b0;

  always #5 clk = ~clk;

  aip_port_initiator #(
    .DATA_WORD (DW),
    .LEN_W     (LW),
    .TMO_W     (16),
    .TMO_CYCLES(TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst_a     (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_config(cmd_cfg),
    .i_cmd_len   (cmd_len),
    .i_wr_data   (wr_data),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .o_rd_data   (rd_data),
    .o_rd_valid  (rd_valid),
    .i_rd_ready  (rd_ready),
    .o_done      (done),
    .o_status    (status),
    .o_configAIP (cfg_aip),
    .o_dataInAIP (din_aip),
    .o_readAIP   (rd_aip),
    .o_writeAIP  (wr_aip),
    .o_startAIP  (st_aip),
    .i_dataOutAIP(dout_aip),
    .i_intAIP    (int_aip)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [36:0]   wq[$];
  int            wcq[$];
  int            w_cnt = 0;
  int            rd_cnt = 0;
  int            st_cnt = 0;
  int            done_cnt = 0;
  int            excl_err = 0;
  int            rd_seq = 0;
  logic [DW-1:0] rd_base = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // slave: data valid only in the cycle after a read strobe, junk otherwise
  always @(posedge clk) begin
    if (rd_aip) begin
      dout_aip <= rd_base + DW'(rd_seq);
      rd_seq   <= rd_seq + 1;
    end else begin
      dout_aip <= DW'($urandom);
    end
  end

  always @(negedge clk) begin
    if (wr_aip) begin
      wq.push_back({cfg_aip, din_aip});
      wcq.push_back(cyc);
      w_cnt <= w_cnt + 1;
    end
    if (rd_aip) rd_cnt <= rd_cnt + 1;
    if (st_aip) st_cnt <= st_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (int'(rd_aip) + int'(wr_aip) + int'(st_aip) > 1)
      excl_err <= excl_err + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] cfg,
                       input logic [LW-1:0] len);
    int b = 0;
    while (!cmd_ready && b < 50) begin
      tick();
      b++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cfg   = cfg;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_cfg   = 5'($urandom);
    cmd_len   = LW'($urandom);
    chk("cmd_cfg", 64'(cfg_aip), 64'(cfg));
    chk("cmd_busy", 64'(cmd_ready), 64'(0));
  endtask

  task automatic wr_burst(input logic [4:0] cfg, input int len,
                          input bit rnd);
    logic [DW-1:0] d[$];
    int            idx = 0;
    int            k = 0;
    int            w0;
    bit            take;
    for (int i = 0; i < len; i++)
      d.push_back(rnd ? DW'($urandom) : DW'(32'h11 * (i + 1)));
    wq.delete();
    wcq.delete();
    w0 = w_cnt;
    issue(2'b00, cfg, LW'(len));
    while (!done && k < 400) begin
      wr_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_data  = (idx < len) ? d[idx] : DW'(32'h55);
      take     = wr_valid && wr_ready;
      tick();
      if (take) idx++;
      k++;
    end
    wr_valid = 1'b0;
    chk("wr_done", 64'(done), 64'(1));
    chk("wr_status", 64'(status), 64'(0));
    chk("wr_accepts", 64'(idx), 64'(len));
    chk("wr_strobes", 64'(w_cnt - w0), 64'(len));
    for (int i = 0; i < len && i < wq.size(); i++)
      chk("wr_word", 64'(wq[i]), 64'({cfg, d[i]}));
    if (len > 0 && wcq.size() > 0) begin
      chk("wr_done_lat", 64'(cyc), 64'(wcq[wcq.size()-1] + 1));
      if (!rnd)
        chk("wr_b2b", 64'(wcq[wcq.size()-1] - wcq[0]), 64'(len - 1));
    end
    tick();
    chk("wr_idle", 64'({cmd_ready, done}), 64'(2'b10));
  endtask

  task automatic rd_burst(input logic [4:0] cfg, input int len,
                          input logic [DW-1:0] base, input int stall_idx,
                          input int stall_n, input bit rnd);
    logic [DW-1:0] got[$];
    logic [DW-1:0] v;
    int            k = 0;
    int            left = stall_n;
    int            hold_err = 0;
    int            r0;
    bit            take;
    rd_base = base - DW'(rd_seq);
    r0 = rd_cnt;
    issue(2'b01, cfg, LW'(len));
    while (!done && k < 400) begin
      if (rd_valid && got.size() == stall_idx && left > 0) begin
        rd_ready = 1'b0;
        left--;
        if (rd_data !== base + DW'(stall_idx)) hold_err++;
      end else begin
        rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      take = rd_valid && rd_ready;
      v    = rd_data;
      tick();
      if (take) got.push_back(v);
      k++;
    end
    rd_ready = 1'b0;
    chk("rd_done", 64'(done), 64'(1));
    chk("rd_status", 64'(status), 64'(0));
    chk("rd_words", 64'(got.size()), 64'(len));
    chk("rd_strobes", 64'(rd_cnt - r0), 64'(len));
    for (int i = 0; i < len && i < got.size(); i++)
      chk("rd_data", 64'(got[i]), 64'(base + DW'(i)));
    if (stall_n > 0) begin
      chk("rd_stalled", 64'(left), 64'(0));
      chk("rd_hold", 64'(hold_err), 64'(0));
    end
    tick();
    chk("rd_idle", 64'({cmd_ready, rd_valid}), 64'(2'b10));
  endtask

  task automatic start_wait(input logic [4:0] cfg, input int d,
                            input bit poke);
    int         s0 = st_cnt;
    int         t = 0;
    int         seen_at;
    int         exp_lat;
    int         dn0;
    logic [1:0] exp_st;
    // int is only looked at from the first wait cycle (t=1) onward
    seen_at = (d < 1) ? 1 : d;
    if (seen_at <= TMO) begin
      exp_lat = seen_at + 1;
      exp_st  = 2'b00;
    end else begin
      exp_lat = TMO + 1;
      exp_st  = 2'b01;
    end
    issue(2'b10, cfg, LW'($urandom));
    chk("st_pulse", 64'(st_aip), 64'(1));
    while (!done && t < 200) begin
      int_aip   = (t >= d);
      cmd_valid = poke && t == 5;
      cmd_op    = 2'b11;
      cmd_cfg   = ~cfg;
      tick();
      t++;
    end
    cmd_valid = 1'b0;
    chk("st_done", 64'(done), 64'(1));
    chk("st_lat", 64'(t), 64'(exp_lat));
    chk("st_status", 64'(status), 64'(exp_st));
    chk("st_cfg", 64'(cfg_aip), 64'(cfg));
    int_aip = 1'b0;
    dn0 = done_cnt;
    tick();
    tick();
    tick();
    chk("st_single", 64'(st_cnt - s0), 64'(1));
    chk("st_one_done", 64'(done_cnt - dn0), 64'(1));
    chk("st_idle", 64'(cmd_ready), 64'(1));
  endtask

  task automatic ill_op(input logic [4:0] cfg);
    int r0 = rd_cnt;
    int w0 = w_cnt;
    int s0 = st_cnt;
    issue(2'b11, cfg, LW'($urandom));
    chk("ill_done", 64'({done, status}), 64'(3'b110));
    tick();
    tick();
    chk("ill_strobes", 64'((rd_cnt - r0) + (w_cnt - w0) + (st_cnt - s0)),
        64'(0));
    chk("ill_idle", 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    int dn0;
    tick();
    tick();
    chk("rst_ctrl", 64'({cmd_ready, wr_ready, rd_valid, done}),
        64'(4'b1000));
    chk("rst_bus", 64'({rd_aip, wr_aip, st_aip, cfg_aip, status}),
        64'(0));
    chk("rst_data", 64'({rd_data, din_aip}), 64'(0));
    rst_n = 1'b1;
    tick();

    wr_burst(5'h02, 4, 1'b0);
    rd_burst(5'h03, 3, 32'hA0, 1, 5, 1'b0);
    start_wait(5'h04, 10, 1'b0);
    start_wait(5'h05, 1000, 1'b0);
    start_wait(5'h06, TMO, 1'b0);
    start_wait(5'h07, TMO + 1, 1'b0);
    start_wait(5'h08, 0, 1'b0);
    ill_op(5'h09);
    wr_burst(5'h0A, 0, 1'b0);
    rd_burst(5'h0B, 0, 32'h0, -1, 0, 1'b0);
    start_wait(5'h0C, 12, 1'b1);

    issue(2'b00, 5'h0D, 8);
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = DW'($urandom);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_strobes", 64'({rd_aip, wr_aip, st_aip}), 64'(0));
    chk("abort_rdy", 64'({cmd_ready, wr_ready, done}), 64'(3'b100));
    dn0 = done_cnt;
    wr_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("abort_nodone", 64'(done_cnt - dn0), 64'(0));
    chk("abort_idle", 64'(cmd_ready), 64'(1));

    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(0, 3))
        0: wr_burst(5'($urandom), int'($urandom_range(0, 10)), 1'b1);
        1: rd_burst(5'($urandom), int'($urandom_range(0, 6)),
                    DW'($urandom), -1, 0, 1'b1);
        2: start_wait(5'($urandom), int'($urandom_range(0, 22)), 1'b0);
        default: ill_op(5'($urandom));
      endcase
    end

    chk("strobe_excl", 64'(excl_err), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
